uart_tx_drain: RTL and testbench

Serial transmitter that drains bytes from the output side of the team's async FIFO and shifts them out as 8N1/8N2 UART frames on `tx`. It sits directly downstream of the FIFO in the serial console path, in the FIFO's read-clock domain. It speaks the FIFO's four-phase read handshake and paces requests so only one byte is outstanding at a time.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/baud_counter.sv | 47 ++++
 rtl/uart_tx_drain.sv | 144 ++++++++++++++
 tb/tb_uart_tx_drain.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared state encoding and constants for the UART blocks
// Rev 1.0  : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  localparam int unsigned UART_DATA_BITS              = 8;
  localparam int unsigned UART_DEFAULT_CLOCKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_START   = 3'd2,
    ST_DATA    = 3'd3,
    ST_STOP    = 3'd4
  } uart_state_e;

  // Counter width for 0..cpb-1; never narrower than one bit.
  function automatic int unsigned baud_cnt_width(input int unsigned cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/baud_counter.sv
// ============================================================================
// baud_counter : free-running bit-period counter with one-cycle terminal tick
// Rev 1.0      : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = UART_DEFAULT_CLOCKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned      CW       = baud_cnt_width(CLOCKS_PER_BIT);
  localparam logic [CW-1:0]    TERMINAL = CW'(CLOCKS_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == TERMINAL) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = enable && (count_q == TERMINAL);

endmodule

`default_nettype wire

// File: rtl/uart_tx_drain.sv
// ============================================================================
// uart_tx_drain : pulls one byte at a time from the async FIFO read side and
//                 sends it as an 8N1/8N2 UART frame on tx
// Rev 1.0       : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = UART_DEFAULT_CLOCKS_PER_BIT,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic       clock,
  input  logic       reset,
  output logic       fifo_ready,
  input  logic       fifo_valid,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  uart_state_e                 state_q, state_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]                  bit_idx_q, bit_idx_d;
  logic                        stop_cnt_q, stop_cnt_d;
  logic                        tx_q, tx_d;
  logic                        fifo_ready_q, fifo_ready_d;
  logic                        busy_q, busy_d;

  logic baud_clear;
  logic baud_enable;
  logic baud_tick;

  baud_counter #(
    .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
  ) u_baud (
    .clock  (clock),
    .reset  (reset),
    .clear  (baud_clear),
    .enable (baud_enable),
    .tick   (baud_tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    baud_clear  = 1'b0;
    baud_enable = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A still-high valid means the previous read has not released yet.
        if (!fifo_empty && !fifo_valid) begin
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (fifo_valid) begin
          shift_d    = fifo_data;
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
          baud_clear = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        baud_enable = 1'b1;
        if (baud_tick) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        baud_enable = 1'b1;
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        baud_enable = 1'b1;
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs decoded from the next state so they leave flops glitch-free.
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    fifo_ready_d = (state_d == ST_REQUEST);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      stop_cnt_q   <= 1'b0;
      tx_q         <= 1'b1;
      fifo_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      stop_cnt_q   <= stop_cnt_d;
      tx_q         <= tx_d;
      fifo_ready_q <= fifo_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_ready = fifo_ready_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
// ============================================================================
// tb_uart_tx_drain : two transmitter instances (4 clk/bit 8N1, 3 clk/bit 8N2)
//                    fed by FIFO models; a UART line decoder checks frames
// Rev 1.0          : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_drain;

  localparam int NL = 2;

  function automatic int lane_cpb(input int l);
    return (l == 0) ? 4 : 3;
  endfunction

  function automatic int lane_stop(input int l);
    return (l == 0) ? 1 : 2;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       f_ready [NL];
  logic       f_valid [NL];
  logic       f_empty [NL];
  logic       tx_s    [NL];
  logic       busy_s  [NL];
  logic [7:0] f_data  [NL];

  // FIFO contents (written by stimulus) and expected frames (pushed on acknowledge)
  logic [7:0] fifo_mem [NL][256];
  int         fifo_wr  [NL];
  int         fifo_rd  [NL];
  logic [7:0] exp_mem  [NL][256];
  int         exp_wr   [NL];
  int         exp_rd   [NL];

  int n_cmp = 0;
  int n_bad = 0;

  generate
    for (genvar l = 0; l < NL; l++) begin : g_lane
      uart_tx_drain #(
        .CLOCKS_PER_BIT (lane_cpb(l)),
        .STOP_BITS      (lane_stop(l))
      ) dut (
        .clock      (clk),
        .reset      (rst_n),
        .fifo_ready (f_ready[l]),
        .fifo_valid (f_valid[l]),
        .fifo_data  (f_data[l]),
        .fifo_empty (f_empty[l]),
        .tx         (tx_s[l]),
        .busy       (busy_s[l])
      );
      assign f_empty[l] = (fifo_wr[l] == fifo_rd[l]);
    end
  endgenerate

  task automatic check(input bit ok, input string name, input int lane,
                       input longint act, input longint req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s lane%0d: got %0h, required %0h", name, lane, act, req);
    end
  endtask

  // Model / monitor state
  int         lat_cnt    [NL];
  int         lat_tgt    [NL];
  logic       prev_ready [NL];
  bit         mon_active [NL];
  bit         mon_tail   [NL];
  bit         mon_skip   [NL];
  int         mon_s      [NL];
  logic [10:0] mon_frame [NL];
  logic [7:0] mon_byte   [NL];
  logic [7:0] mon_rx     [NL];
  int         mon_bad    [NL][11];
  int         frames     [NL];
  int         lost       [NL];
  int         dropped    [NL];

  // FIFO read-side model followed by the UART line decoder, once per negedge
  initial begin
    for (int l = 0; l < NL; l++) begin
      fifo_rd[l] = 0; exp_wr[l] = 0; exp_rd[l] = 0;
      lat_cnt[l] = 0; lat_tgt[l] = 2; prev_ready[l] = 1'b0;
      f_valid[l] = 1'b0; f_data[l] = 8'h00;
      mon_active[l] = 1'b0; mon_tail[l] = 1'b0; mon_skip[l] = 1'b0; mon_s[l] = 0;
      mon_frame[l] = '1; mon_byte[l] = 8'h00; mon_rx[l] = 8'h00;
      frames[l] = 0; lost[l] = 0; dropped[l] = 0;
    end
    forever begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        if (!rst_n) begin
          if (f_valid[l]) begin
            fifo_rd[l]++;
            lost[l]++;
          end
          f_valid[l] = 1'b0;
          lat_cnt[l] = 0;
          prev_ready[l] = 1'b0;
          if (mon_active[l]) dropped[l]++;
          dropped[l] += exp_wr[l] - exp_rd[l];
          exp_rd[l] = exp_wr[l];
          mon_active[l] = 1'b0;
          mon_tail[l] = 1'b0;
        end else begin
          int cpb;
          int nb;
          int b;
          cpb = lane_cpb(l);
          nb  = 9 + lane_stop(l);

          if (f_ready[l] && !prev_ready[l]) begin
            check(!f_valid[l] && !f_empty[l], "ready_rise valid/empty", l,
                  {f_valid[l], f_empty[l]}, 2'b00);
          end
          prev_ready[l] = f_ready[l];

          if (f_valid[l]) begin
            if (!f_ready[l]) begin
              exp_mem[l][exp_wr[l] % 256] = fifo_mem[l][fifo_rd[l] % 256];
              exp_wr[l]++;
              fifo_rd[l]++;
              f_valid[l] = 1'b0;
              f_data[l] = 8'($urandom);
              check(tx_s[l] == 1'b0, "latch_to_start_tx", l, tx_s[l], 0);
            end
          end else begin
            f_data[l] = 8'($urandom);
            if (f_ready[l] && !f_empty[l]) begin
              lat_cnt[l]++;
              if (lat_cnt[l] >= lat_tgt[l]) begin
                f_valid[l] = 1'b1;
                f_data[l]  = fifo_mem[l][fifo_rd[l] % 256];
                lat_cnt[l] = 0;
                lat_tgt[l] = int'($urandom_range(1, 3));
              end
            end else begin
              lat_cnt[l] = 0;
            end
          end

          if (mon_tail[l]) begin
            check(busy_s[l] == 1'b0 && tx_s[l] == 1'b1, "frame_end busy,tx", l,
                  {busy_s[l], tx_s[l]}, 2'b01);
            mon_tail[l] = 1'b0;
          end else if (!mon_active[l] && tx_s[l] == 1'b0) begin
            check(exp_wr[l] != exp_rd[l], "frame_expected pending", l,
                  exp_wr[l] - exp_rd[l], 1);
            mon_skip[l] = (exp_wr[l] == exp_rd[l]);
            if (!mon_skip[l]) begin
              mon_byte[l] = exp_mem[l][exp_rd[l] % 256];
              exp_rd[l]++;
            end
            mon_frame[l] = {2'b11, mon_byte[l], 1'b0};
            mon_active[l] = 1'b1;
            mon_s[l] = 0;
            mon_rx[l] = 8'h00;
            for (int k = 0; k < 11; k++) mon_bad[l][k] = 0;
          end

          if (mon_active[l]) begin
            b = mon_s[l] / cpb;
            if (tx_s[l] !== mon_frame[l][b] || busy_s[l] !== 1'b1) mon_bad[l][b]++;
            if (b >= 1 && b <= 8 && (mon_s[l] % cpb) == cpb / 2) mon_rx[l][b-1] = tx_s[l];
            mon_s[l]++;
            if (mon_s[l] == nb * cpb) begin
              if (!mon_skip[l]) begin
                for (int k = 0; k < nb; k++) begin
                  check(mon_bad[l][k] == 0,
                        $sformatf("frame_bit%0d wrong samples (level %0b)", k, mon_frame[l][k]),
                        l, mon_bad[l][k], 0);
                end
                check(mon_rx[l] == mon_byte[l], "rx_byte", l, mon_rx[l], mon_byte[l]);
              end
              frames[l]++;
              mon_active[l] = 1'b0;
              mon_tail[l] = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic push(input int l, input logic [7:0] b);
    fifo_mem[l][fifo_wr[l] % 256] = b;
    fifo_wr[l]++;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      done = 1'b1;
      for (int l = 0; l < NL; l++) begin
        if (fifo_wr[l] != fifo_rd[l] || exp_wr[l] != exp_rd[l] || mon_active[l] ||
            mon_tail[l] || f_valid[l] || busy_s[l]) done = 1'b0;
      end
    end
    check(done, "drain_complete", 0, done, 1);
  endtask

  initial begin
    int viol [NL];
    bit found;

    for (int l = 0; l < NL; l++) fifo_wr[l] = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset held with data waiting: outputs must stay inactive.
    push(0, 8'hA5);
    push(1, 8'h55);
    repeat (5) begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        check(tx_s[l] === 1'b1 && f_ready[l] === 1'b0 && busy_s[l] === 1'b0,
              "reset_outputs tx,ready,busy", l, {tx_s[l], f_ready[l], busy_s[l]}, 3'b100);
      end
    end
    #1 rst_n = 1'b1;
    drain();

    // Two queued bytes per lane
    for (int l = 0; l < NL; l++) begin
      push(l, 8'h00);
      push(l, 8'hFF);
    end
    drain();

    // Empty FIFO for 100 cycles: line stays idle, no requests
    for (int l = 0; l < NL; l++) viol[l] = 0;
    repeat (100) begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        if (f_ready[l] !== 1'b0 || tx_s[l] !== 1'b1 || busy_s[l] !== 1'b0) viol[l]++;
      end
    end
    for (int l = 0; l < NL; l++) check(viol[l] == 0, "empty_idle_violations", l, viol[l], 0);

    // Random bytes at random times on random lanes
    repeat (40) begin
      push(int'($urandom_range(0, 1)), 8'($urandom));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    drain();

    // Asynchronous reset in the middle of data bit 3 of lane 0
    push(0, 8'hA5);
    push(0, 8'h3C);
    push(1, 8'($urandom));
    push(1, 8'($urandom));
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (tx_s[0] == 1'b0) found = 1'b1;
    end
    check(found, "start_bit_seen", 0, found, 1);
    repeat (17) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check(tx_s[0] === 1'b1 && f_ready[0] === 1'b0 && busy_s[0] === 1'b0,
             "async_reset_outputs tx,ready,busy", 0, {tx_s[0], f_ready[0], busy_s[0]}, 3'b100);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    drain();

    // Every byte handed out is either framed, lost to reset, or abandoned by reset
    for (int l = 0; l < NL; l++) begin
      check(frames[l] + lost[l] + dropped[l] == fifo_wr[l], "byte_accounting", l,
            frames[l] + lost[l] + dropped[l], fifo_wr[l]);
    end
    check(frames[0] >= 1 && dropped[0] >= 1, "reset_frame_recovery", 0,
          {frames[0][15:0], dropped[0][15:0]}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
